// File: rtl/pulsegen_pkg.sv
// pulsegen_pkg: shared types and constants for the multi-channel pulse generator.
//   state_t  : per-channel FSM states (IDLE, DELAY, HIGH)
//   CFG_*    : cfg_sel encodings for the configuration registers
//   RST_*    : configuration register reset values
package pulsegen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    HIGH  = 2'd2
  } state_t;

  localparam logic [1:0] CFG_DLY = 2'd0;
  localparam logic [1:0] CFG_WID = 2'd1;
  localparam logic [1:0] CFG_REP = 2'd2;
  localparam logic [1:0] CFG_POL = 2'd3;

  localparam int   RST_DLY = 0;
  localparam int   RST_WID = 1;
  localparam int   RST_REP = 1;
  localparam logic RST_POL = 1'b0;

endpackage

// File: rtl/pulse_chan.sv
// pulse_chan: one pulse generator channel (config regs, working copies, FSM,
// delay/width counter, repeat counter, registered output).
// Optional feature macro: PULSEGEN_POL_EN (per-channel output polarity).
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   i_cfg_we              : write strobe already decoded for this channel
//   i_cfg_sel, i_cfg_data : register select and write data
//   i_trig, i_stop        : start / abort levels
//   o_pulse               : registered pulse output
//   o_busy                : channel not in IDLE
//   o_done                : one-cycle strobe after a finite burst completes
module pulse_chan
  import pulsegen_pkg::*;
#(
  parameter int CW = 26,
  parameter int RW = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_cfg_we,
  input  logic [1:0]    i_cfg_sel,
  input  logic [CW-1:0] i_cfg_data,
  input  logic          i_trig,
  input  logic          i_stop,
  output logic          o_pulse,
  output logic          o_busy,
  output logic          o_done
);

  localparam logic [CW-1:0] C_ONE = CW'(1);
  localparam logic [RW-1:0] R_ONE = RW'(1);

  logic [CW-1:0] r_dly, r_wid, r_wdly, r_wwid;
  logic [RW-1:0] r_rep, r_wrep;
  state_t        r_state, w_state_next;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic [RW-1:0] r_rep_cnt, w_rep_cnt_next;
  logic          w_load, w_done_next, w_active_next, w_pulse_next;
  logic          r_pulse, r_done;

  // Configuration registers, writable at any time.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dly <= CW'(RST_DLY);
      r_wid <= CW'(RST_WID);
      r_rep <= RW'(RST_REP);
    end else if (i_cfg_we) begin
      case (i_cfg_sel)
        CFG_DLY: r_dly <= i_cfg_data;
        CFG_WID: r_wid <= i_cfg_data;
        CFG_REP: r_rep <= i_cfg_data[RW-1:0];
        default: ;
      endcase
    end
  end

  // Working copies captured at start; WID=0 is folded to 1 here so the
  // HIGH-state compare never sees zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wdly <= CW'(RST_DLY);
      r_wwid <= CW'(RST_WID);
      r_wrep <= RW'(RST_REP);
    end else if (w_load) begin
      r_wdly <= r_dly;
      r_wwid <= (r_wid == '0) ? C_ONE : r_wid;
      r_wrep <= r_rep;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_rep_cnt <= '0;
      r_pulse   <= RST_POL;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_rep_cnt <= w_rep_cnt_next;
      r_pulse   <= w_pulse_next;
      r_done    <= w_done_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_rep_cnt_next = r_rep_cnt;
    w_done_next    = 1'b0;
    w_load         = 1'b0;
    if (i_stop) begin
      w_state_next = IDLE;
      w_cnt_next   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_trig) begin
            w_load         = 1'b1;
            w_cnt_next     = '0;
            w_rep_cnt_next = '0;
            // Zero delay skips DELAY so the first active cycle is t+1.
            w_state_next   = (r_dly == '0) ? HIGH : DELAY;
          end
        end
        DELAY: begin
          if (r_cnt == r_wdly - C_ONE) begin
            w_cnt_next   = '0;
            w_state_next = HIGH;
          end else begin
            w_cnt_next = r_cnt + C_ONE;
          end
        end
        HIGH: begin
          if (r_cnt == r_wwid - C_ONE) begin
            w_cnt_next = '0;
            if (r_wrep != '0 && r_rep_cnt == r_wrep - R_ONE) begin
              w_state_next = IDLE;
              w_done_next  = 1'b1;
            end else begin
              // Continuous mode holds the repeat counter so it never wraps.
              if (r_wrep != '0) w_rep_cnt_next = r_rep_cnt + R_ONE;
              w_state_next = (r_wdly == '0) ? HIGH : DELAY;
            end
          end else begin
            w_cnt_next = r_cnt + C_ONE;
          end
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  assign w_active_next = (w_state_next == HIGH);

`ifdef PULSEGEN_POL_EN
  logic r_pol, r_wpol, w_pol_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pol <= RST_POL;
    end else if (i_cfg_we && i_cfg_sel == CFG_POL) begin
      r_pol <= i_cfg_data[0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wpol <= RST_POL;
    end else if (w_load) begin
      r_wpol <= r_pol;
    end
  end

  // Idle level follows the live POL; a running burst keeps its captured POL.
  assign w_pol_next   = (w_state_next == IDLE || w_load) ? r_pol : r_wpol;
  assign w_pulse_next = w_active_next ^ w_pol_next;
`else
  assign w_pulse_next = w_active_next;
`endif

  assign o_pulse = r_pulse;
  assign o_busy  = (r_state != IDLE);
  assign o_done  = r_done;

endmodule

// File: rtl/pulsegen_mc.sv
// pulsegen_mc: NCH independent programmable pulse generator channels.
// Optional feature macro: PULSEGEN_POL_EN (per-channel output polarity).
// Ports:
//   clk, reset_n        : clock, asynchronous active-low reset
//   cfg_we              : configuration write strobe
//   cfg_ch              : target channel (values >= NCH are dropped)
//   cfg_sel, cfg_data   : register select (DLY/WID/REP/POL) and data
//   trig, stop          : per-channel start / abort levels
//   pulse_out, busy, done : per-channel outputs
module pulsegen_mc
  import pulsegen_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CW  = 26,
  parameter int RW  = 8
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  cfg_we,
  input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] cfg_ch,
  input  logic [1:0]                            cfg_sel,
  input  logic [CW-1:0]                         cfg_data,
  input  logic [NCH-1:0]                        trig,
  input  logic [NCH-1:0]                        stop,
  output logic [NCH-1:0]                        pulse_out,
  output logic [NCH-1:0]                        busy,
  output logic [NCH-1:0]                        done
);

  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_chan
      logic w_we;
      // Out-of-range channel numbers match no instance and are dropped.
      assign w_we = cfg_we && (cfg_ch == CHW'(gi));

      pulse_chan #(
        .CW (CW),
        .RW (RW)
      ) u_chan (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_cfg_we   (w_we),
        .i_cfg_sel  (cfg_sel),
        .i_cfg_data (cfg_data),
        .i_trig     (trig[gi]),
        .i_stop     (stop[gi]),
        .o_pulse    (pulse_out[gi]),
        .o_busy     (busy[gi]),
        .o_done     (done[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_pulsegen_mc.sv
// tb_pulsegen_mc: scoreboard bench for pulsegen_mc. The driver applies inputs
// on the falling edge and pushes the outputs expected in the following cycle,
// computed from each burst's start cycle with plain arithmetic. The monitor
// samples just after each rising edge, pops and compares.
module tb_pulsegen_mc;

  localparam int NCH = 4;
  localparam int CW  = 26;
  localparam int RW  = 8;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           cfg_we = 1'b0;
  logic [1:0]     cfg_ch = '0;
  logic [1:0]     cfg_sel = '0;
  logic [CW-1:0]  cfg_data = '0;
  logic [NCH-1:0] trig = '0;
  logic [NCH-1:0] stop = '0;
  logic [NCH-1:0] pulse_out, busy, done;

  pulsegen_mc #(.NCH(NCH), .CW(CW), .RW(RW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_sel   (cfg_sel),
    .cfg_data  (cfg_data),
    .trig      (trig),
    .stop      (stop),
    .pulse_out (pulse_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NCH-1:0] pulse;
    logic [NCH-1:0] busy;
    logic [NCH-1:0] done;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int mcyc = 0;

  // Reference model: configuration shadow plus the parameters of the running burst.
  int m_dly[NCH], m_wid[NCH], m_rep[NCH];
  bit m_pol[NCH];
  bit m_act[NCH];
  int m_t0[NCH], m_d[NCH], m_w[NCH], m_r[NCH];
  bit m_wpol[NCH];

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_dly[i] = 0; m_wid[i] = 1; m_rep[i] = 1; m_pol[i] = 0;
      m_act[i] = 0; m_t0[i] = 0; m_d[i] = 0; m_w[i] = 1; m_r[i] = 1; m_wpol[i] = 0;
    end
  endtask

  task automatic chk(input string name, input int c, input logic [NCH-1:0] act, input logic [NCH-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%b required=%b", name, c, act, req);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        mcyc++;
        chk("pulse_out", mcyc, pulse_out, e.pulse);
        chk("busy", mcyc, busy, e.busy);
        chk("done", mcyc, done, e.done);
      end
    end
  end

  // One cycle of stimulus: drive inputs for cycle c and push outputs expected at c+1.
  task automatic step(input logic [NCH-1:0] tr, input logic [NCH-1:0] st, input logic we,
                      input int ch, input int sel, input int data, input bit rst);
    exp_t e;
    int c, n, p;
    bit busy_c, eb, ed, ea;
    @(negedge clk);
    cyc++;
    c = cyc;
    n = c + 1;
    e = '0;
    if (rst) begin
      reset_n  = 1'b0;
      trig     = '0;
      stop     = '0;
      cfg_we   = 1'b0;
      model_reset();
      exp_q.push_back(e);
      return;
    end
    reset_n  = 1'b1;
    trig     = tr;
    stop     = st;
    cfg_we   = we;
    cfg_ch   = ch[1:0];
    cfg_sel  = sel[1:0];
    cfg_data = CW'(data);
    for (int i = 0; i < NCH; i++) begin
      p = m_d[i] + m_w[i];
      busy_c = m_act[i] && (m_r[i] == 0 || c <= m_t0[i] + m_r[i] * p);
      if (!busy_c) m_act[i] = 0;
      if (st[i]) begin
        m_act[i] = 0;
      end else if (!busy_c && tr[i]) begin
        m_act[i]  = 1;
        m_t0[i]   = c;
        m_d[i]    = m_dly[i];
        m_w[i]    = (m_wid[i] == 0) ? 1 : m_wid[i];
        m_r[i]    = m_rep[i];
        m_wpol[i] = m_pol[i];
        $display("trig  cycle=%0d ch=%0d dly=%0d wid=%0d rep=%0d pol=%0d",
                 c, i, m_d[i], m_w[i], m_r[i], m_wpol[i]);
      end
      p  = m_d[i] + m_w[i];
      eb = m_act[i] && (m_r[i] == 0 || n <= m_t0[i] + m_r[i] * p);
      ed = m_act[i] && m_r[i] != 0 && n == m_t0[i] + m_r[i] * p + 1;
      ea = eb && (((n - m_t0[i] - 1) % p) >= m_d[i]);
      e.pulse[i] = ea ^ (eb ? m_wpol[i] : m_pol[i]);
      e.busy[i]  = eb;
      e.done[i]  = ed;
    end
    if (we && ch < NCH) begin
      case (sel)
        0: m_dly[ch] = data;
        1: m_wid[ch] = data;
        2: m_rep[ch] = data & ((1 << RW) - 1);
`ifdef PULSEGEN_POL_EN
        3: m_pol[ch] = data[0];
`endif
        default: ;
      endcase
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int k);
    repeat (k) step('0, '0, 1'b0, 0, 0, 0, 1'b0);
  endtask

  task automatic wr(input int ch, input int sel, input int data);
    step('0, '0, 1'b1, ch, sel, data, 1'b0);
  endtask

  task automatic trg(input int ch);
    logic [NCH-1:0] v;
    v = '0;
    v[ch] = 1'b1;
    step(v, '0, 1'b0, 0, 0, 0, 1'b0);
  endtask

  task automatic stp(input int ch, input bit with_trig);
    logic [NCH-1:0] v;
    v = '0;
    v[ch] = 1'b1;
    step(with_trig ? v : '0, v, 1'b0, 0, 0, 0, 1'b0);
  endtask

  initial begin
    logic [NCH-1:0] tr, st;
    int sel, data;
    model_reset();
    repeat (4) step('0, '0, 1'b0, 0, 0, 0, 1'b1);
    idle(3);

    // ch0: DLY=3 WID=2 REP=1, single trigger
    wr(0, 0, 3); wr(0, 1, 2); wr(0, 2, 1);
    trg(0); idle(9);

    // ch1: DLY=0 WID=0 REP=3 -> three back-to-back one-cycle pulses
    wr(1, 0, 0); wr(1, 1, 0); wr(1, 2, 3);
    trg(1); idle(7);

    // ch2: continuous period-3 train, stopped in a HIGH cycle
    wr(2, 2, 0); wr(2, 0, 2); wr(2, 1, 1);
    trg(2); idle(8); stp(2, 0); idle(4);

    // ch0: write during burst and retrigger while busy; next burst uses WID=7
    wr(0, 0, 5); wr(0, 1, 2); wr(0, 2, 1);
    trg(0); idle(2); wr(0, 1, 7); trg(0); idle(8);
    trg(0); idle(15);

    // ch1: trig held high restarts right after done
    wr(1, 0, 1); wr(1, 1, 1); wr(1, 2, 2);
    repeat (12) step(4'b0010, '0, 1'b0, 0, 0, 0, 1'b0);
    idle(3);

    // ch3: trig and stop together in IDLE
    stp(3, 1); idle(3);

    // ch1: polarity write, then a burst
    wr(1, 3, 1); wr(1, 0, 1); wr(1, 1, 3); wr(1, 2, 2);
    idle(2); trg(1); idle(12); wr(1, 3, 0); idle(3);

    // ch0: continuous burst, reset asserted during HIGH
    wr(0, 0, 1); wr(0, 1, 4); wr(0, 2, 0);
    trg(0); idle(3);
    step('0, '0, 1'b0, 0, 0, 0, 1'b1);
    idle(4);

    // Randomised traffic
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < NCH; i++) begin
        tr[i] = ($urandom_range(0, 4) == 0);
        st[i] = ($urandom_range(0, 39) == 0);
      end
      sel = $urandom_range(0, 3);
      case (sel)
        0: data = $urandom_range(0, 6);
        1: data = $urandom_range(0, 5);
        2: data = $urandom_range(0, 4) + (($urandom_range(0, 3) == 0) ? 256 : 0);
        default: data = $urandom_range(0, 3);
      endcase
      step(tr, st, ($urandom_range(0, 3) == 0), $urandom_range(0, NCH - 1), sel, data,
           ($urandom_range(0, 599) == 0));
    end
    idle(2);

    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pulsegen_mc.md
# pulsegen_mc

Multi-channel programmable pulse generator, the parametrised successor of the single-channel fixed delay/width generator. Each of `NCH` channels emits, on trigger, a burst of pulses with runtime-programmable delay, width and repeat count, or runs continuously. It sits between the control register bank and the timing outputs (strobes, ADC gates, test stimulus), all in the `clk` domain.

## Interface
- `NCH`, 4, number of independent channels (1..16)
- `CW`, 26, delay/width counter width in bits
- `RW`, 8, repeat-count width in bits
- `clk`  in  1  system clock, rising edge
- `reset_n`  in  1  asynchronous active-low reset; deassertion is synchronised externally
- `cfg_we`  in  1  configuration write strobe, one cycle
- `cfg_ch`  in  $clog2(NCH)  target channel; writes with `cfg_ch >= NCH` are dropped
- `cfg_sel`  in  2  0 = delay, 1 = width, 2 = repeat, 3 = polarity (bit 0 only)
- `cfg_data`  in  CW  write data; upper bits truncated for repeat and polarity
- `trig`  in  NCH  per-channel start, level sampled each cycle
- `stop`  in  NCH  per-channel abort, level sampled each cycle
- `pulse_out`  out  NCH  registered pulse outputs
- `busy`  out  NCH  channel not in IDLE
- `done`  out  NCH  one-cycle strobe when a finite burst completes

## Operation
- Per channel, configuration registers DLY[CW], WID[CW], REP[RW], POL. Reset values: DLY=0, WID=1, REP=1, POL=0.
- Writes land in the configuration registers at any time. On start, the channel copies them into working registers, so writes during a burst affect only the next trigger.
- FSM per channel: IDLE -> DELAY -> HIGH -> (DELAY | IDLE).
- IDLE: `trig` high and `stop` low -> load working copies and clear the repeat counter -> DELAY.
- DELAY: holds for DLY cycles. DLY=0 passes straight through to HIGH in the same transition.
- HIGH: active level for WID cycles; WID=0 is treated as 1. At end, increment the repeat counter. Then go to IDLE with `done` if the count equals REP and REP != 0. Otherwise go to DELAY. DLY is the inter-pulse gap.
- REP=0: continuous mode, repeats until `stop`. `done` never fires.
- `trig` while busy is ignored. Retrigger requires the channel to be in IDLE; a level held high restarts immediately after `done`.
- `stop` in any state -> IDLE next cycle, output to inactive level, no `done`. `stop` and `trig` in the same cycle: `stop` wins.
- Active level is `~POL` when the polarity feature is compiled in, else 1. Inactive level is its complement.
- Counters saturate-free: they count up to the loaded value minus 1 and then compare. Widths equal `CW`/`RW`, with no wrap possible.
- Channels are fully independent; no shared arbitration.

## Timing
- Reset: all FSMs IDLE; `pulse_out`=0, or 1 if the channel's reset POL yields an inactive high level (POL=0 gives 0); `busy`=0; `done`=0.
- `trig` sampled in cycle t: `busy`=1 from t+1. The first active `pulse_out` cycle is t+1+DLY, and it lasts WID cycles.
- Pulse period in a burst is DLY+WID cycles.
- `done` asserts in the cycle after the last active cycle, together with `busy`=0.
- Config write in cycle t is visible to a trigger sampled in cycle t+1.
- Mid-operation `reset_n` assertion: immediate return to reset values, configuration included.

## Configuration
- `PULSEGEN_POL_EN` defined: `cfg_sel`=3 writes POL; the output is inverted per channel when POL=1.
- Without it: `cfg_sel`=3 writes are dropped, POL reads as 0, the active level is always 1, and there is no inversion logic.

## Structure
- Package `pulsegen_pkg`: state enum (IDLE, DELAY, HIGH), `cfg_sel` encodings (CFG_DLY, CFG_WID, CFG_REP, CFG_POL), reset constants.
- Sub-module `pulse_chan`: one channel holding its config registers, FSM, counters and output register. The top instantiates `NCH` copies in a generate loop and decodes `cfg_ch`.

## Test plan
- Reset then DLY=3, WID=2, REP=1 on ch0, trig at t=10 -> `pulse_out[0]` high at cycles 14–15, `done[0]` at 16, `busy[0]` 11–15.
- DLY=0, WID=0, REP=3 on ch1 -> three 1-cycle pulses at t+1, t+2, t+3, `done` at t+4.
- REP=0, DLY=2, WID=1 on ch2 -> period-3 pulse train. `stop` mid-HIGH -> output low next cycle, `busy` low, no `done`.
- ch0 busy with DLY=5; write WID=7 and pulse `trig` again -> current burst keeps old width and the retrigger is ignored; the next trigger after `done` uses WID=7.
- `trig` and `stop` asserted together on ch3 in IDLE -> stays IDLE; `reset_n` low during HIGH -> all outputs at reset values on the next edge.
- With `PULSEGEN_POL_EN`: POL=1 on ch1 -> idle high, active low for WID cycles. Without it: same writes leave ch1 active-high.
